// File: rtl/legv8_cw_sequencer.sv
// Programmable control-word sequencer: plays (cw, dwell, last) entries from a small store
// into the LEGv8 datapath ControlWord input, with stop-or-loop at program end.
module legv8_cw_sequencer #(
  parameter int unsigned CW_WIDTH = 40,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DWELL_W  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [CW_WIDTH-1:0]      load_cw,
  input  logic [DWELL_W-1:0]       load_dwell,
  input  logic                     load_last,
  input  logic                     loop_mode,
  input  logic                     start,
  input  logic                     halt,
  output logic [CW_WIDTH-1:0]      control_word,
  output logic [$clog2(DEPTH)-1:0] step_index,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [CW_WIDTH-1:0] cw_mem    [DEPTH];
  logic [DWELL_W-1:0]  dwell_mem [DEPTH];
  logic                last_mem  [DEPTH];

  // Entry 0 as seen by a start: a same-cycle load of entry 0 takes precedence
  logic                load_hits0;
  logic [CW_WIDTH-1:0] start_cw;
  logic [DWELL_W-1:0]  start_dwell;
  logic                entry_end;

  always_comb begin
    load_hits0  = load_en && (load_addr == IW'(0));
    start_cw    = load_hits0 ? load_cw    : cw_mem[0];
    start_dwell = load_hits0 ? load_dwell : dwell_mem[0];
    entry_end   = last_mem[step_index] || (step_index == IW'(DEPTH - 1));
  end

  // Program store; writes are blocked while a program is playing
  always_ff @(posedge clock) begin
    if (!reset && load_en && (state != RUN)) begin
      cw_mem[load_addr]    <= load_cw;
      dwell_mem[load_addr] <= load_dwell;
      last_mem[load_addr]  <= load_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      control_word <= '0;
      step_index   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dwell_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (halt) begin
            state        <= IDLE;
            control_word <= '0;
            step_index   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dwell_cnt    <= '0;
          end else if (start) begin
            state        <= RUN;
            control_word <= start_cw;
            step_index   <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            dwell_cnt    <= start_dwell;
          end
        end
        RUN: begin
          if (halt) begin
            state        <= IDLE;
            control_word <= '0;
            step_index   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dwell_cnt    <= '0;
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end else if (!entry_end) begin
            control_word <= cw_mem[step_index + IW'(1)];
            dwell_cnt    <= dwell_mem[step_index + IW'(1)];
            step_index   <= step_index + IW'(1);
          end else if (loop_mode) begin
            control_word <= cw_mem[0];
            dwell_cnt    <= dwell_mem[0];
            step_index   <= '0;
          end else begin
            state        <= DONE;
            control_word <= '0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          control_word <= '0;
          step_index   <= '0;
          busy         <= 1'b0;
          done         <= 1'b0;
          dwell_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_cw_sequencer.sv
// Directed bench for legv8_cw_sequencer: playback, loop, halt, load protection, implicit end, reset.
module tb_legv8_cw_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_en, load_last, loop_mode, start, halt;
  logic [3:0]  load_addr, load_dwell, step_index;
  logic [39:0] load_cw, control_word;
  logic        busy, done;

  logic        l4_en, start4;
  logic [1:0]  l4_addr, step4;
  logic [39:0] l4_cw, cw4;
  logic        busy4, done4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  legv8_cw_sequencer dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_cw(load_cw), .load_dwell(load_dwell), .load_last(load_last),
    .loop_mode(loop_mode), .start(start), .halt(halt),
    .control_word(control_word), .step_index(step_index), .busy(busy), .done(done)
  );

  legv8_cw_sequencer #(.CW_WIDTH(40), .DEPTH(4), .DWELL_W(4)) dut4 (
    .clock(clock), .reset(reset), .load_en(l4_en), .load_addr(l4_addr),
    .load_cw(l4_cw), .load_dwell(4'd0), .load_last(1'b0),
    .loop_mode(1'b0), .start(start4), .halt(1'b0),
    .control_word(cw4), .step_index(step4), .busy(busy4), .done(done4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [39:0] cw, input logic [3:0] dw,
                      input logic last);
    load_en = 1'b1; load_addr = a; load_cw = cw; load_dwell = dw; load_last = last;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    logic [39:0] basic [5];
    logic [39:0] loopseq [10];
    basic   = '{40'h1, 40'h2, 40'h2, 40'h2, 40'h3};
    loopseq = '{40'h1, 40'h2, 40'h2, 40'h2, 40'h3, 40'h1, 40'h2, 40'h2, 40'h2, 40'h3};

    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_cw = '0; load_dwell = '0;
    load_last = 1'b0; loop_mode = 1'b0; start = 1'b0; halt = 1'b0;
    l4_en = 1'b0; l4_addr = '0; l4_cw = '0; start4 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_cw", 64'(control_word), 64'h0);
    chk("rst_idx", 64'(step_index), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);

    load(4'd0, 40'h1, 4'd0, 1'b0);
    load(4'd1, 40'h2, 4'd2, 1'b0);
    load(4'd2, 40'h3, 4'd0, 1'b1);

    // Basic playback: 1,2,2,2,3 then done
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("basic_cw%0d", k), 64'(control_word), 64'(basic[k]));
      chk($sformatf("basic_busy%0d", k), 64'(busy), 64'h1);
      tick();
    end
    chk("basic_end_cw", 64'(control_word), 64'h0);
    chk("basic_end_done", 64'(done), 64'h1);
    chk("basic_end_busy", 64'(busy), 64'h0);

    // Loop mode, then drop loop_mode during the last entry
    loop_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("loop_cw%0d", k), 64'(control_word), 64'(loopseq[k]));
      chk($sformatf("loop_done%0d", k), 64'(done), 64'h0);
      tick();
    end
    chk("loop_wrap_cw", 64'(control_word), 64'h1);
    tick(); tick(); tick(); tick();
    chk("loop_last_cw", 64'(control_word), 64'h3);
    chk("loop_last_idx", 64'(step_index), 64'h2);
    loop_mode = 1'b0;
    tick();
    chk("loop_stop_cw", 64'(control_word), 64'h0);
    chk("loop_stop_done", 64'(done), 64'h1);

    // Halt in the second hold cycle of entry 1
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("halt_pre_cw", 64'(control_word), 64'h2);
    halt = 1'b1; tick(); halt = 1'b0;
    chk("halt_cw", 64'(control_word), 64'h0);
    chk("halt_busy", 64'(busy), 64'h0);
    chk("halt_done", 64'(done), 64'h0);
    start = 1'b1; tick(); start = 1'b0;
    chk("halt_replay_cw", 64'(control_word), 64'h1);

    // Load during RUN is ignored
    load(4'd1, 40'hFF, 4'd0, 1'b0);
    chk("prot_run_cw", 64'(control_word), 64'h2);
    tick(); tick(); tick(); tick();
    chk("prot_run_done", 64'(done), 64'h1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("prot_replay_cw", 64'(control_word), 64'h2);
    tick(); tick(); tick(); tick();
    chk("prot_replay_done", 64'(done), 64'h1);

    // Load entry 0 plus start in DONE plays the new word
    load_cw = 40'hAA; load_addr = 4'd0; load_dwell = 4'd0; load_last = 1'b0;
    load_en = 1'b1; start = 1'b1; tick(); load_en = 1'b0; start = 1'b0;
    chk("load_start_cw", 64'(control_word), 64'hAA);
    chk("load_start_busy", 64'(busy), 64'h1);
    halt = 1'b1; tick(); halt = 1'b0;

    // start with halt from IDLE stays IDLE
    start = 1'b1; halt = 1'b1; tick(); start = 1'b0; halt = 1'b0;
    chk("sh_busy", 64'(busy), 64'h0);
    chk("sh_cw", 64'(control_word), 64'h0);
    tick();
    chk("sh_busy2", 64'(busy), 64'h0);

    // Implicit end at DEPTH-1 on the 4-entry instance
    for (int i = 0; i < 4; i++) begin
      l4_en = 1'b1; l4_addr = 2'(i); l4_cw = 40'h10 + 40'(i);
      tick();
    end
    l4_en = 1'b0;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("impl_cw%0d", i), 64'(cw4), 64'h10 + 64'(i));
      chk($sformatf("impl_idx%0d", i), 64'(step4), 64'(i));
      chk($sformatf("impl_busy%0d", i), 64'(busy4), 64'h1);
      tick();
    end
    chk("impl_done", 64'(done4), 64'h1);
    chk("impl_busy_end", 64'(busy4), 64'h0);
    chk("impl_cw_end", 64'(cw4), 64'h0);

    // Reset during RUN; restore entry 0 first so playback is the original program
    load(4'd0, 40'h1, 4'd0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("rrun_pre_cw", 64'(control_word), 64'h2);
    reset = 1'b1; tick();
    chk("rrun_cw1", 64'(control_word), 64'h0);
    tick(); reset = 1'b0;
    chk("rrun_cw", 64'(control_word), 64'h0);
    chk("rrun_idx", 64'(step_index), 64'h0);
    chk("rrun_busy", 64'(busy), 64'h0);
    chk("rrun_done", 64'(done), 64'h0);
    chk("rrun_done4", 64'(done4), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
